// File: rtl/imm_extend_pipe_pkg.sv
// imm_extend_pipe_pkg
//   Shared constants for the pipelined immediate extend unit.
//   IMMSRC_* : 3-bit format select codes presented on in_immsrc.
//   XLEN_DEFAULT : default datapath width of the extended immediate.
package imm_extend_pipe_pkg;

  localparam logic [2:0] IMMSRC_I   = 3'b000;
  localparam logic [2:0] IMMSRC_S   = 3'b001;
  localparam logic [2:0] IMMSRC_B   = 3'b010;
  localparam logic [2:0] IMMSRC_J   = 3'b011;
  localparam logic [2:0] IMMSRC_U   = 3'b100;
  localparam logic [2:0] IMMSRC_Z   = 3'b101;
  // 3'b110 and 3'b111 are both illegal; this is the canonical one.
  localparam logic [2:0] IMMSRC_ILL = 3'b110;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/imm_pipe_stage.sv
// imm_pipe_stage
//   Generic valid/ready register slice. Loads whenever it is empty or its
//   content is being taken downstream in the same cycle, so a full stage
//   passes one item per cycle with no bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid, o_ready    upstream handshake (o_ready = load condition)
//   i_data              upstream payload
//   o_valid, i_ready    downstream handshake
//   o_data              registered payload, stable while o_valid && !i_ready
module imm_pipe_stage #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      // Payload only moves with a real item, so outputs do not flicker
      // through bubbles.
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined RV32I immediate extend unit. Decodes instruction bits [31:7]
//   according to a 3-bit format select into an XLEN-wide immediate, then
//   passes it (with a sideband tag and an illegal-format flag) through
//   PIPE_STAGES valid/ready register slices.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             request handshake
//   in_instr[24:0]                instruction bits [31:7]
//   in_immsrc[2:0]                format select (I,S,B,J,U,Z; 11x illegal)
//   in_tag[TAG_W-1:0]             sideband carried with the result
//   out_valid/out_ready           result handshake
//   out_imm[XLEN-1:0]             extended immediate
//   out_tag, out_illegal          tag and illegal-select flag of out_imm
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int DW = XLEN + TAG_W + 1;

  generate
    if (!(XLEN == 32 || XLEN == 64) || !(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_param
      $error("imm_extend_pipe: XLEN must be 32/64 and PIPE_STAGES must be 1/2");
    end
  endgenerate

  // Returns {illegal, imm32}. Every format fits in 32 bits with bit 31 as
  // the correct sign, so widening to XLEN is a plain sign extension
  // (the zimm case has bit 31 clear, so it stays zero-extended).
  function automatic logic [32:0] decode_imm(input logic [31:7] instr,
                                             input logic [2:0]  src);
    logic [32:0] res;
    res = '0;
    case (src)
      IMMSRC_I: res[31:0] = {{20{instr[31]}}, instr[31:20]};
      IMMSRC_S: res[31:0] = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMMSRC_B: res[31:0] = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
      IMMSRC_J: res[31:0] = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
      IMMSRC_U: res[31:0] = {instr[31:12], 12'b0};
      IMMSRC_Z: res[31:0] = {27'b0, instr[19:15]};
      default:  res       = {1'b1, 32'b0};
    endcase
    return res;
  endfunction

  logic [32:0]     w_dec;
  logic [31:0]     w_imm32;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;

  assign w_dec     = decode_imm(in_instr, in_immsrc);
  assign w_imm32   = w_dec[31:0];
  assign w_illegal = w_dec[32];

  generate
    if (XLEN == 64) begin : g_x64
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_x32
      assign w_imm = w_imm32;
    end
  endgenerate

  // Index k is the link feeding stage k; index PIPE_STAGES is the output.
  logic [PIPE_STAGES:0] w_valid;
  logic [PIPE_STAGES:0] w_ready;
  logic [DW-1:0]        w_data [PIPE_STAGES+1];

  assign w_valid[0]           = in_valid;
  assign w_data[0]            = {w_illegal, in_tag, w_imm};
  assign in_ready             = w_ready[0];
  assign w_ready[PIPE_STAGES] = out_ready;

  generate
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      imm_pipe_stage #(.W(DW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_valid[k]),
        .o_ready (w_ready[k]),
        .i_data  (w_data[k]),
        .o_valid (w_valid[k+1]),
        .i_ready (w_ready[k+1]),
        .o_data  (w_data[k+1])
      );
    end
  endgenerate

  assign out_valid                       = w_valid[PIPE_STAGES];
  assign {out_illegal, out_tag, out_imm} = w_data[PIPE_STAGES];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Two instances: dut_a (XLEN=32, 1 stage) for format decode vectors,
//   dut_b (XLEN=64, 2 stages) for 64-bit extension, backpressure,
//   throughput and asynchronous reset behaviour.
module tb_imm_extend_pipe;
  import imm_extend_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [24:0] a_in_instr;
  logic [2:0]  a_in_immsrc;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_imm;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [24:0] b_in_instr;
  logic [2:0]  b_in_immsrc;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [63:0] b_out_imm;

  imm_extend_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .in_immsrc(a_in_immsrc), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_tag(a_out_tag), .out_illegal(a_out_illegal)
  );

  imm_extend_pipe #(.XLEN(64), .PIPE_STAGES(2), .TAG_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .in_immsrc(b_in_immsrc), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on dut_a; result expected one cycle after accept.
  task automatic send_a(input string tag, input logic [24:0] instr, input logic [2:0] src,
                        input logic [4:0] t, input logic [31:0] exp_imm, input logic exp_ill);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_instr = instr; a_in_immsrc = src; a_in_tag = t;
    @(negedge clk);
    chk({tag, "_in_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, a_out_valid, 1);
    chk({tag, "_imm"}, a_out_imm, exp_imm);
    chk({tag, "_tag"}, a_out_tag, t);
    chk({tag, "_illegal"}, a_out_illegal, exp_ill);
  endtask

  // One request on dut_b; result must not appear after one cycle, only after two.
  task automatic send_b(input string tag, input logic [24:0] instr, input logic [2:0] src,
                        input logic [4:0] t, input logic [63:0] exp_imm, input logic exp_ill);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_instr = instr; b_in_immsrc = src; b_in_tag = t;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, b_out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, b_out_valid, 1);
    chk({tag, "_imm"}, b_out_imm, exp_imm);
    chk({tag, "_tag"}, b_out_tag, t);
    chk({tag, "_illegal"}, b_out_illegal, exp_ill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, first, nres;
    logic held, saw_full;
    logic [63:0] held_imm;
    logic [4:0]  held_tag;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_instr = '0; a_in_immsrc = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 0; b_in_instr = '0; b_in_immsrc = '0; b_in_tag = '0; b_out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_imm", a_out_imm, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_out_illegal", a_out_illegal, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready_a", a_in_ready, 1);
    chk("post_rst_in_ready_b", b_in_ready, 1);

    // Format decode, XLEN=32, 1 stage.
    send_a("d90_I", 25'd90, IMMSRC_I, 5'd0, 32'h0000_0000, 1'b0);
    send_a("d90_S", 25'd90, IMMSRC_S, 5'd1, 32'h0000_001A, 1'b0);
    send_a("d90_B", 25'd90, IMMSRC_B, 5'd2, 32'h0000_001A, 1'b0);
    send_a("d90_U", 25'd90, IMMSRC_U, 5'd3, 32'h0000_2000, 1'b0);
    send_a("d90_J", 25'd90, IMMSRC_J, 5'd4, 32'h0000_2000, 1'b0);
    send_a("ones_I", 25'h1FFFFFF, IMMSRC_I, 5'd5, 32'hFFFF_FFFF, 1'b0);
    send_a("ones_B", 25'h1FFFFFF, IMMSRC_B, 5'd6, 32'hFFFF_FFFE, 1'b0);
    send_a("ones_U", 25'h1FFFFFF, IMMSRC_U, 5'd8, 32'hFFFF_F000, 1'b0);
    send_a("ones_Z", 25'h1FFFFFF, IMMSRC_Z, 5'd9, 32'h0000_001F, 1'b0);
    send_a("ones_J", 25'h1FFFFFF, IMMSRC_J, 5'd10, 32'hFFFF_FFFE, 1'b0);
    send_a("ill_110", 25'h1FFFFFF, 3'b110, 5'd7, 32'h0000_0000, 1'b1);
    send_a("ill_111", 25'd90, 3'b111, 5'd11, 32'h0000_0000, 1'b1);

    // XLEN=64, 2 stages.
    send_b("x64_U", 25'h1FFFFFF, IMMSRC_U, 5'd1, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
    send_b("x64_I", 25'h1FFFFFF, IMMSRC_I, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_b("x64_Z", 25'h1FFFFFF, IMMSRC_Z, 5'd3, 64'h0000_0000_0000_001F, 1'b0);
    send_b("x64_S", 25'd90, IMMSRC_S, 5'd4, 64'h0000_0000_0000_001A, 1'b0);
    send_b("x64_ill", 25'd90, 3'b111, 5'd5, 64'h0, 1'b1);

    // Stream of 6 with a 4-cycle stall; zimm payload equals the tag.
    sent = 0; recv = 0; held = 0; saw_full = 0; held_imm = '0; held_tag = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(posedge clk); #1;
      b_in_valid  = (sent < 6);
      b_in_tag    = 5'(sent);
      b_in_instr  = 25'(sent) << 8;
      b_in_immsrc = IMMSRC_Z;
      b_out_ready = !(c >= 3 && c < 7);
      @(negedge clk);
      if (b_out_valid && held) begin
        chk("stream_hold_tag", b_out_tag, held_tag);
        chk("stream_hold_imm", b_out_imm, held_imm);
      end
      if (b_in_valid && !b_in_ready && !saw_full) begin
        saw_full = 1;
        chk("stream_full_depth", sent - recv, 2);
      end
      if (b_out_valid && b_out_ready) begin
        chk("stream_tag", b_out_tag, 5'(recv));
        chk("stream_imm", b_out_imm, 64'(recv));
        recv++;
        held = 0;
      end else if (b_out_valid) begin
        held = 1; held_tag = b_out_tag; held_imm = b_out_imm;
      end
      if (b_in_valid && b_in_ready) sent++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    chk("stream_recv_count", recv, 6);
    chk("stream_sent_count", sent, 6);
    chk("stream_saw_full", saw_full, 1);

    // Full-rate streaming: 10 requests, expect 10 results on consecutive cycles.
    first = -1; nres = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      b_in_valid = (c < 10);
      b_in_tag   = 5'(c);
      b_in_instr = 25'(c) << 8;
      @(negedge clk);
      if (b_in_valid) chk("tput_in_ready", b_in_ready, 1);
      if (b_out_valid) begin
        if (first < 0) first = c;
        chk("tput_tag", b_out_tag, 5'(nres));
        chk("tput_cycle", c, first + nres);
        nres++;
      end
    end
    b_in_valid = 1'b0;
    chk("tput_latency", first, 2);
    chk("tput_count", nres, 10);

    // Asynchronous reset with one result waiting and one item in flight.
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_tag = 5'd10; b_in_instr = 25'd10 << 8;
    @(posedge clk); #1;
    b_in_tag = 5'd11; b_in_instr = 25'd11 << 8;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_valid", b_out_valid, 1);
    chk("rstmid_pre_tag", b_out_tag, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", b_out_valid, 0);
    chk("rstmid_tag", b_out_tag, 0);
    chk("rstmid_imm", b_out_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    chk("rstmid_in_ready", b_in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstmid_no_stale", b_out_valid, 0);
    end
    send_b("rstmid_new", 25'd12 << 8, IMMSRC_Z, 5'd12, 64'd12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
